// File: rtl/lsu_replay_scheduler_pkg.sv
// Shared LSU memory-packet types and replay queue sizing used by the replay scheduler slice.
package lsu_replay_scheduler_pkg;

  localparam int SIZE_REPLAY_Q     = 4;
  localparam int SIZE_REPLAY_Q_LOG = 2;
  localparam int SEQ_W             = 8;
  localparam int ADDR_W            = 32;
  localparam int DATA_W            = 32;

  typedef struct packed {
    logic       destValid;
    logic       signExt;
    logic [1:0] accSize;
  } exeFlgs;

  typedef struct packed {
    logic              valid;
    logic [SEQ_W-1:0]  seqNo;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    exeFlgs            flags;
  } memPkt;

endpackage

// File: rtl/lsu_replay_scheduler_if.sv
// Packet-side bundle between the AGEN/replay sources, the replay scheduler and the load/store paths.
interface lsu_replay_scheduler_if #(
  parameter int DEPTH = lsu_replay_scheduler_pkg::SIZE_REPLAY_Q
);
  import lsu_replay_scheduler_pkg::*;

  logic                    recoverFlag_i;
  memPkt                   memPacket_i;
  memPkt                   replayReq_i;
  memPkt                   ldPacket_o;
  memPkt                   stPacket_o;
  logic                    replayGrant_o;
  logic                    agenStall_o;
  logic [$clog2(DEPTH):0]  replayCount_o;
  logic                    replayOverflow_o;

  modport master (
    output recoverFlag_i, memPacket_i, replayReq_i,
    input  ldPacket_o, stPacket_o, replayGrant_o, agenStall_o, replayCount_o, replayOverflow_o
  );

  modport slave (
    input  recoverFlag_i, memPacket_i, replayReq_i,
    output ldPacket_o, stPacket_o, replayGrant_o, agenStall_o, replayCount_o, replayOverflow_o
  );

endinterface

// File: rtl/lsu_replay_fifo.sv
// Replay-load FIFO: circular memPkt storage with combinational head, occupancy count and flush.
module lsu_replay_fifo
  import lsu_replay_scheduler_pkg::*;
#(
  parameter int DEPTH = SIZE_REPLAY_Q
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  memPkt                  pushData,
  output memPkt                  headData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  memPkt            mem [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else if (flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + PTR_W'(1);
      if (pop)  headPtr <= headPtr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is data only; a write at full lands on the slot being popped this cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tailPtr] <= pushData;
  end

  assign headData = mem[headPtr];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/lsu_replay_scheduler.sv
// Steers AGEN packets or a queued replay load onto the single cache slot, and forces a one-cycle
// AGEN stall when a replay has waited too long or the replay queue is nearly full.
module lsu_replay_scheduler
  import lsu_replay_scheduler_pkg::*;
#(
  parameter int DEPTH        = SIZE_REPLAY_Q,
  parameter int STARVE_LIMIT = 8
) (
  input logic                  clk,
  input logic                  reset,
  lsu_replay_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(DEPTH - 1);

  memPkt            headData;
  memPkt            ldPacket;
  memPkt            stPacket;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic             full;
  logic             empty;
  logic             deq;
  logic             enqReq;
  logic             push;
  logic             overflowSet;
  logic [AGE_W-1:0] age_p0;
  logic [AGE_W-1:0] ageNext;
  logic             stall_p0;
  logic             stallNext;
  logic             overflow_p0;

  lsu_replay_fifo #(.DEPTH(DEPTH)) replayFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (deq),
    .flush    (bus.recoverFlag_i),
    .pushData (bus.replayReq_i),
    .headData (headData),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // AGEN owns the slot whenever it is valid; the replay head only fills idle cycles.
  always_comb begin
    ldPacket = '0;
    stPacket = '0;
    deq      = 1'b0;
    if (bus.memPacket_i.valid) begin
      if (bus.memPacket_i.flags.destValid) ldPacket = bus.memPacket_i;
      else                                 stPacket = bus.memPacket_i;
    end else if (!empty && !bus.recoverFlag_i) begin
      ldPacket = headData;
      deq      = 1'b1;
    end
  end

  always_comb begin
    enqReq      = bus.replayReq_i.valid && !bus.recoverFlag_i;
    push        = enqReq && (!full || deq);
    overflowSet = enqReq && full && !deq;
    countNext   = bus.recoverFlag_i ? '0 : count + CNT_W'(push) - CNT_W'(deq);
    ageNext     = '0;
    if (!bus.recoverFlag_i && !deq && countNext != '0)
      ageNext = (age_p0 == AGE_MAX) ? age_p0 : age_p0 + AGE_W'(1);
    // Never stall two cycles running so AGEN always gets issue slots back.
    stallNext = !bus.recoverFlag_i && (countNext != '0) && !stall_p0 &&
                ((ageNext == AGE_MAX) || (countNext >= CNT_HIGH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_p0      <= '0;
      stall_p0    <= 1'b0;
      overflow_p0 <= 1'b0;
    end else begin
      age_p0   <= ageNext;
      stall_p0 <= stallNext;
      if (overflowSet) overflow_p0 <= 1'b1;
    end
  end

  assign bus.ldPacket_o       = ldPacket;
  assign bus.stPacket_o       = stPacket;
  assign bus.replayGrant_o    = deq;
  assign bus.agenStall_o      = stall_p0;
  assign bus.replayCount_o    = count;
  assign bus.replayOverflow_o = overflow_p0;

endmodule

// File: tb/tb_lsu_replay_scheduler.sv
// Cycle-stepped bench for lsu_replay_scheduler: a queue scoreboard holds the expected replay order
// and occupancy, alongside independent age/stall/overflow tracking, checked every cycle.
module tb_lsu_replay_scheduler;
  import lsu_replay_scheduler_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_replay_scheduler_if #(.DEPTH(DEPTH)) bus ();

  lsu_replay_scheduler #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int    testsRun  = 0;
  int    failCount = 0;
  memPkt sbQ[$];
  int    mAge;
  logic  mStall;
  logic  mOverflow;
  memPkt obsLd;
  memPkt obsSt;
  logic  obsGrant;
  logic  obsStall;
  memPkt idle;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic memPkt mkPkt(input logic v, input logic dv, input int seq);
    memPkt p;
    p                 = '0;
    p.valid           = v;
    p.flags.destValid = dv;
    p.flags.accSize   = 2'(seq);
    p.seqNo           = SEQ_W'(seq);
    p.address         = 32'(32'h1000 + seq * 4);
    p.data            = $urandom;
    return p;
  endfunction

  task automatic modelReset();
    sbQ.delete();
    mAge      = 0;
    mStall    = 1'b0;
    mOverflow = 1'b0;
  endtask

  // One clock: drive after the edge, compare at the falling edge, then advance the model.
  task automatic step(input memPkt mp, input memPkt rr, input logic rec);
    memPkt expLd;
    memPkt expSt;
    logic  expGrant;
    if (mStall) mp.valid = 1'b0;
    bus.memPacket_i   = mp;
    bus.replayReq_i   = rr;
    bus.recoverFlag_i = rec;
    expLd    = '0;
    expSt    = '0;
    expGrant = 1'b0;
    if (mp.valid && mp.flags.destValid) expLd = mp;
    else if (mp.valid)                  expSt = mp;
    else if (sbQ.size() > 0 && !rec) begin
      expLd    = sbQ[0];
      expGrant = 1'b1;
    end
    @(negedge clk);
    obsLd    = bus.ldPacket_o;
    obsSt    = bus.stPacket_o;
    obsGrant = bus.replayGrant_o;
    obsStall = bus.agenStall_o;
    checkVal("ldPacket", 128'(obsLd), 128'(expLd));
    checkVal("stPacket", 128'(obsSt), 128'(expSt));
    checkVal("replayGrant", 128'(obsGrant), 128'(expGrant));
    checkVal("agenStall", 128'(obsStall), 128'(mStall));
    checkVal("replayCount", 128'(bus.replayCount_o), 128'(sbQ.size()));
    checkVal("replayOverflow", 128'(bus.replayOverflow_o), 128'(mOverflow));
    if (rec) begin
      sbQ.delete();
      mAge   = 0;
      mStall = 1'b0;
    end else begin
      if (expGrant) void'(sbQ.pop_front());
      if (rr.valid) begin
        if (sbQ.size() < DEPTH) sbQ.push_back(rr);
        else                    mOverflow = 1'b1;
      end
      if (expGrant || sbQ.size() == 0) mAge = 0;
      else if (mAge < LIMIT - 1)       mAge++;
      mStall = !mStall && sbQ.size() != 0 && (mAge == LIMIT - 1 || sbQ.size() >= DEPTH - 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stallCnt;
    int grantCnt;
    idle              = '0;
    bus.memPacket_i   = '0;
    bus.replayReq_i   = '0;
    bus.recoverFlag_i = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_count", 128'(bus.replayCount_o), 128'(0));
    checkVal("rst_stall", 128'(bus.agenStall_o), 128'(0));
    checkVal("rst_overflow", 128'(bus.replayOverflow_o), 128'(0));
    checkVal("rst_grant", 128'(bus.replayGrant_o), 128'(0));
    checkVal("rst_ld", 128'(bus.ldPacket_o), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Idle
    step(idle, idle, 1'b0);
    step(idle, idle, 1'b0);
    checkVal("t1_ld", 128'(obsLd), 128'(0));
    checkVal("t1_st", 128'(obsSt), 128'(0));

    // AGEN load beats a queued replay, which follows in the next idle cycle
    step(idle, mkPkt(1'b1, 1'b1, 9), 1'b0);
    step(mkPkt(1'b1, 1'b1, 5), idle, 1'b0);
    checkVal("t2_agen_seq", 128'(obsLd.seqNo), 128'(5));
    checkVal("t2_agen_grant", 128'(obsGrant), 128'(0));
    step(idle, idle, 1'b0);
    checkVal("t2_replay_seq", 128'(obsLd.seqNo), 128'(9));
    checkVal("t2_replay_grant", 128'(obsGrant), 128'(1));
    checkVal("t2_count_after", 128'(bus.replayCount_o), 128'(0));

    // Starvation stall under continuous AGEN
    step(idle, mkPkt(1'b1, 1'b1, 20), 1'b0);
    stallCnt = 0;
    grantCnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(mkPkt(1'b1, 1'b1, 30 + i), idle, 1'b0);
      if (obsStall) stallCnt++;
      if (obsGrant) grantCnt++;
      if (i == 6) checkVal("t3_stall_cycle", 128'(obsStall), 128'(1));
    end
    checkVal("t3_stall_pulses", 128'(stallCnt), 128'(1));
    checkVal("t3_grants", 128'(grantCnt), 128'(1));

    // Fill: stall pulses, enq+deq at full, then overflow
    for (int i = 0; i < 6; i++) step(mkPkt(1'b1, 1'b0, 40 + i), mkPkt(1'b1, 1'b1, 50 + i), 1'b0);
    checkVal("t4_full_count", 128'(bus.replayCount_o), 128'(4));
    checkVal("t4_no_overflow", 128'(bus.replayOverflow_o), 128'(0));
    step(mkPkt(1'b1, 1'b0, 46), mkPkt(1'b1, 1'b1, 56), 1'b0);
    checkVal("t4_overflow", 128'(bus.replayOverflow_o), 128'(1));
    step(idle, idle, 1'b0);
    checkVal("t4_overflow_sticky", 128'(bus.replayOverflow_o), 128'(1));

    // Recover with entries queued and an enqueue pending
    step(idle, idle, 1'b1);
    for (int i = 0; i < 4; i++) step(mkPkt(1'b1, 1'b1, 60 + i), mkPkt(1'b1, 1'b1, 70 + i), 1'b0);
    checkVal("t5_count_pre", 128'(bus.replayCount_o), 128'(3));
    step(mkPkt(1'b1, 1'b0, 77), mkPkt(1'b1, 1'b1, 99), 1'b1);
    checkVal("t5_no_grant", 128'(obsGrant), 128'(0));
    checkVal("t5_store_seq", 128'(obsSt.seqNo), 128'(77));
    checkVal("t5_count_after", 128'(bus.replayCount_o), 128'(0));
    checkVal("t5_stall_after", 128'(bus.agenStall_o), 128'(0));

    // Streaming replays across pointer wrap
    grantCnt = 0;
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      step(idle, mkPkt(1'b1, 1'b1, 100 + i), 1'b0);
      if (obsGrant) grantCnt++;
    end
    for (int i = 0; i < 2; i++) begin
      step(idle, idle, 1'b0);
      if (obsGrant) grantCnt++;
    end
    checkVal("t6_grant_total", 128'(grantCnt), 128'(2 * DEPTH + 1));

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(mkPkt(1'b1, 1'b1, 120 + i), mkPkt(1'b1, 1'b1, 130 + i), 1'b0);
    bus.memPacket_i = '0;
    bus.replayReq_i = '0;
    #2;
    reset = 1'b1;
    #1;
    checkVal("t6_arst_count", 128'(bus.replayCount_o), 128'(0));
    checkVal("t6_arst_stall", 128'(bus.agenStall_o), 128'(0));
    checkVal("t6_arst_overflow", 128'(bus.replayOverflow_o), 128'(0));
    checkVal("t6_arst_grant", 128'(bus.replayGrant_o), 128'(0));
    checkVal("t6_arst_ld", 128'(bus.ldPacket_o), 128'(0));
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(idle, idle, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
